// File: rtl/clk_div_multi.sv
// ============================================================================
// clk_div_multi : multi-channel divided clock / tick / single-step generator
// Rev 1.0       : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clk_div_multi #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = 24,
  parameter int DEFAULT_DIV  = 100000,
  parameter int DEFAULT_MODE = 1
) (
  input  logic                I_CLK,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [1:0]          cfg_mode,
  input  logic [CHANNELS-1:0] step,
  output logic [CHANNELS-1:0] O_CLK,
  output logic [CHANNELS-1:0] O_TICK,
  output logic [CHANNELS-1:0] cfg_pending
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_TICK   = 2'd2,
    MODE_STEP   = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_DEF_DIV  = (DEFAULT_DIV < 1) ? C_ONE : CNT_W'(DEFAULT_DIV);
  localparam mode_e            C_DEF_MODE = mode_e'(2'(DEFAULT_MODE));

  // A programmed divisor of zero behaves as one.
  logic [CNT_W-1:0] w_cfg_div_sat;
  assign w_cfg_div_sat = (cfg_div == '0) ? C_ONE : cfg_div;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    mode_e            mode_q, mode_d;
    logic             w_sel;
    logic             w_last;

    assign w_sel  = cfg_we && (cfg_ch == 3'(i));
    assign w_last = (cnt_q == (div_act_q - C_ONE));

    always_comb begin
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      div_pend_d = div_pend_q;
      pend_d     = pend_q;
      clk_d      = clk_q;
      tick_d     = 1'b0;
      busy_d     = busy_q;
      mode_d     = mode_q;

      if (w_sel) begin
        // A write always restarts the channel; it also supersedes any wrap this cycle.
        mode_d = mode_e'(cfg_mode);
        cnt_d  = '0;
        clk_d  = 1'b0;
        busy_d = 1'b0;
        if ((mode_e'(cfg_mode) == MODE_OFF) || (mode_e'(cfg_mode) == MODE_STEP)) begin
          div_act_d = w_cfg_div_sat;
          pend_d    = 1'b0;
        end else begin
          div_pend_d = w_cfg_div_sat;
          pend_d     = 1'b1;
        end
      end else begin
        case (mode_q)
          MODE_TOGGLE, MODE_TICK: begin
            if (w_last) begin
              cnt_d  = '0;
              tick_d = 1'b1;
              clk_d  = (mode_q == MODE_TOGGLE) ? ~clk_q : 1'b0;
              // Pending divisor lands only at a period boundary, so cnt restarts from 0.
              if (pend_q) begin
                div_act_d = div_pend_q;
                pend_d    = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + C_ONE;
              if (mode_q == MODE_TICK) begin
                clk_d = 1'b0;
              end
            end
          end
          MODE_STEP: begin
            if (busy_q) begin
              if (w_last) begin
                cnt_d  = '0;
                clk_d  = 1'b0;
                busy_d = 1'b0;
                tick_d = 1'b1;
              end else begin
                cnt_d = cnt_q + C_ONE;
              end
            end else begin
              cnt_d = '0;
              clk_d = 1'b0;
              if (step[i]) begin
                busy_d = 1'b1;
                clk_d  = 1'b1;
              end
            end
          end
          default: begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            busy_d = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge I_CLK) begin
      if (rst) begin
        cnt_q      <= '0;
        div_act_q  <= C_DEF_DIV;
        div_pend_q <= C_DEF_DIV;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        busy_q     <= 1'b0;
        mode_q     <= C_DEF_MODE;
      end else begin
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        div_pend_q <= div_pend_d;
        pend_q     <= pend_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
        busy_q     <= busy_d;
        mode_q     <= mode_d;
      end
    end

    assign O_CLK[i]       = clk_q;
    assign O_TICK[i]      = tick_q;
    assign cfg_pending[i] = pend_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// tb_clk_div_multi : scoreboard bench for clk_div_multi (2 channels, div 4)
// Rev 1.0          : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clk_div_multi;

  localparam int CW = 8;

  logic          I_CLK    = 1'b0;
  logic          rst      = 1'b1;
  logic          cfg_we   = 1'b0;
  logic [2:0]    cfg_ch   = 3'd0;
  logic [CW-1:0] cfg_div  = '0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [1:0]    step     = 2'b00;
  logic [1:0]    O_CLK;
  logic [1:0]    O_TICK;
  logic [1:0]    cfg_pending;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [1:0] clk;
    logic [1:0] tick;
    logic [1:0] pend;
    logic [1:0] chm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Deferred-divisor window, edges 15..24 after the initial reset release.
  logic [1:0] dv_clk  [10] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
  logic [1:0] dv_tick [10] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11};
  logic [1:0] dv_pend [10] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  // Single step pulse of 3 cycles followed by idle.
  logic       sp_clk  [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       sp_tick [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 I_CLK = ~I_CLK;

  clk_div_multi #(
    .CHANNELS     (2),
    .CNT_W        (CW),
    .DEFAULT_DIV  (4),
    .DEFAULT_MODE (1)
  ) dut (
    .I_CLK       (I_CLK),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .step        (step),
    .O_CLK       (O_CLK),
    .O_TICK      (O_TICK),
    .cfg_pending (cfg_pending)
  );

  task automatic adv(input int n);
    repeat (n) @(posedge I_CLK);
    #1;
  endtask

  task automatic expect_o(input string nm, input logic [1:0] c, input logic [1:0] t,
                          input logic [1:0] p, input logic [1:0] m);
    exp_t e;
    e.name = nm;
    e.clk  = c;
    e.tick = t;
    e.pend = p;
    e.chm  = m;
    sb.push_back(e);
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [1:0] md, input logic [CW-1:0] dv);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = md;
    cfg_div  = dv;
    adv(1);
    cfg_we   = 1'b0;
  endtask

  // Monitor: every pushed expectation is matched to the outputs of the following low phase.
  initial begin
    forever begin
      @(negedge I_CLK);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        if ((((O_CLK ^ mon_e.clk) | (O_TICK ^ mon_e.tick) | (cfg_pending ^ mon_e.pend)) & mon_e.chm) != 2'b00) begin
          failures++;
          $display("FAIL %s: got clk=%b tick=%b pend=%b, want clk=%b tick=%b pend=%b (channel mask %b)",
                   mon_e.name, O_CLK, O_TICK, cfg_pending, mon_e.clk, mon_e.tick, mon_e.pend, mon_e.chm);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    adv(2);
    expect_o("reset", 2'b00, 2'b00, 2'b00, 2'b11);
    rst = 1'b0;

    for (int k = 1; k <= 12; k++) begin
      adv(1);
      expect_o($sformatf("release_edge%0d", k), ((k / 4) % 2 == 1) ? 2'b11 : 2'b00,
               (k % 4 == 0) ? 2'b11 : 2'b00, 2'b00, 2'b11);
    end

    // ch0 at cnt=1: rewrite TOGGLE with div 2.
    adv(1);
    cfg_write(3'd0, 2'd1, 8'd2);
    expect_o("defer_write", 2'b10, 2'b00, 2'b01, 2'b11);
    for (int j = 0; j < 10; j++) begin
      adv(1);
      expect_o($sformatf("defer_edge%0d", j + 15), dv_clk[j], dv_tick[j], dv_pend[j], 2'b11);
    end

    // ch1 TICK with divisor 0 (treated as 1) after the old 4-cycle period.
    cfg_write(3'd1, 2'd2, 8'd0);
    expect_o("tick_write", 2'b00, 2'b00, 2'b10, 2'b10);
    for (int n = 26; n <= 33; n++) begin
      adv(1);
      expect_o($sformatf("tick_edge%0d", n), 2'b00, (n >= 29) ? 2'b10 : 2'b00,
               (n <= 28) ? 2'b10 : 2'b00, 2'b10);
    end

    // ch0 STEP div 3, one-cycle step pulse.
    cfg_write(3'd0, 2'd3, 8'd3);
    expect_o("step_write", 2'b00, 2'b00, 2'b00, 2'b01);
    step = 2'b01;
    for (int i = 0; i < 5; i++) begin
      adv(1);
      step = 2'b00;
      expect_o($sformatf("step_pulse%0d", i), {1'b0, sp_clk[i]}, {1'b0, sp_tick[i]}, 2'b00, 2'b01);
    end

    // Re-request while busy must be ignored.
    for (int i = 0; i < 6; i++) begin
      step = (i == 0 || i == 2) ? 2'b01 : 2'b00;
      adv(1);
      expect_o($sformatf("step_busy%0d", i), (i < 3) ? 2'b01 : 2'b00,
               (i == 3) ? 2'b01 : 2'b00, 2'b00, 2'b01);
    end

    // Step held 10 cycles: 3 high / 1 low repeating.
    for (int i = 0; i < 13; i++) begin
      step = (i < 10) ? 2'b01 : 2'b00;
      adv(1);
      expect_o($sformatf("step_held%0d", i), ((i % 4 == 3) || (i == 12)) ? 2'b00 : 2'b01,
               (i % 4 == 3) ? 2'b01 : 2'b00, 2'b00, 2'b01);
    end
    step = 2'b00;

    // Start a step on ch0 while ch1 gets a pending divisor, then reset.
    step     = 2'b01;
    cfg_we   = 1'b1;
    cfg_ch   = 3'd1;
    cfg_mode = 2'd2;
    cfg_div  = 8'd5;
    adv(1);
    cfg_we = 1'b0;
    expect_o("step_and_pend", 2'b01, 2'b00, 2'b10, 2'b11);
    rst = 1'b1;
    adv(1);
    expect_o("reset_mid", 2'b00, 2'b00, 2'b00, 2'b11);
    rst  = 1'b0;
    step = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      adv(1);
      expect_o($sformatf("rerelease_edge%0d", k), (k == 4) ? 2'b11 : 2'b00,
               (k == 4) ? 2'b11 : 2'b00, 2'b00, 2'b11);
    end

    // Write to a nonexistent channel must not disturb anything.
    cfg_write(3'd5, 2'd0, 8'd1);
    expect_o("bad_ch_edge5", 2'b11, 2'b00, 2'b00, 2'b11);
    for (int k = 6; k <= 8; k++) begin
      adv(1);
      expect_o($sformatf("bad_ch_edge%0d", k), (k == 8) ? 2'b00 : 2'b11,
               (k == 8) ? 2'b11 : 2'b00, 2'b00, 2'b11);
    end

    adv(3);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
